// File: rtl/elastic_buffer.sv
// Elastic FIFO stage that registers one operand stream on the valid/stop handshake.
// Latency: 1 cycle from push to head of queue (no bypass); 1 transfer/cycle sustained at DEPTH>=2.
// Backpressure: stop_input depends only on registered occupancy, which breaks the stop path.
module elastic_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  valid_input,
  output logic                  stop_input,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  valid_output,
  input  logic                  stop_output,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wp_q, wp_d;
  logic [PTR_WIDTH-1:0]  rp_q, rp_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  push;
  logic                  pop;

  // Pointers wrap explicitly so non-power-of-two depths stay inside the array.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Transfers happening at the coming edge; both handshake flags come from registered state.
  always_comb begin
    push = valid_input && !stop_input;
    pop  = valid_output && !stop_output;
  end

  // Next-state pointers and count; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wp_d  = push ? ptr_inc(wp_q) : wp_q;
    rp_d  = pop  ? ptr_inc(rp_q) : rp_q;
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // Control state; reset empties the queue immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage is not reset; an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= input_data;
    end
  end

  // Outputs are pure functions of registered state, with no path from valid_input or stop_output.
  always_comb begin
    valid_output = (cnt_q != '0);
    stop_input   = (cnt_q == CNT_WIDTH'(DEPTH));
    output_data  = mem_q[rp_q];
    occupancy    = cnt_q;
  end

  // Simulation checks: count bounds and the producer's hold-while-stopped obligation.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
    cnt_q <= CNT_WIDTH'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (cnt_q != CNT_WIDTH'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (cnt_q != '0));
  a_producer_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (valid_input && stop_input) |=> (valid_input && $stable(input_data)));

endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
- Elastic FIFO stage placed directly upstream of the PE's elastic fork; registers one operand stream using the codebase's valid/stop handshake.
- Breaks the combinational stop path between the fork's consumers and the producer.
- Default depth 2 sustains one transfer per cycle.
- Exposes occupancy for simulator statistics and debug.

Parameters:
- DATA_WIDTH, 32: payload width in bits; matches the global DATA_WIDTH.
- DEPTH, 2: number of storage slots; legal values are 2 or more.
- PTR_WIDTH, $clog2(DEPTH): read/write pointer width. Derived; do not override.
- CNT_WIDTH, $clog2(DEPTH+1): occupancy counter width. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- input_data  input  DATA_WIDTH  payload from producer.
- valid_input  input  1  producer offers input_data this cycle.
- stop_input  output  1  buffer refuses the offer; producer must hold data and valid.
- output_data  output  DATA_WIDTH  head-of-queue payload to the fork.
- valid_output  output  1  head entry is present.
- stop_output  input  1  fork refuses the head entry this cycle.
- occupancy  output  CNT_WIDTH  number of stored entries, 0..DEPTH.

Behaviour:
- Transfers:
  - Input transfer (push) occurs on a rising edge where valid_input=1 and stop_input=0.
  - Output transfer (pop) occurs on a rising edge where valid_output=1 and stop_output=0.
- Storage: circular array of DEPTH entries with write pointer wp, read pointer rp and count cnt.
  - Each pointer wraps from DEPTH-1 to 0, including for non-power-of-two DEPTH.
- Push: mem[wp] <= input_data; wp advances.
- Pop: rp advances.
- Count update:
  - cnt increments on push only.
  - cnt decrements on pop only.
  - cnt is unchanged when push and pop occur together, or when neither occurs.
- Derived outputs:
  - valid_output = (cnt != 0).
  - output_data = mem[rp]. Value is don't-care when cnt=0; the bench must not check it then.
  - stop_input = (cnt == DEPTH).
  - occupancy = cnt.
  - All four are functions of registered state only. There is no combinational path from valid_input or stop_output to any output.
- Latency: a datum pushed at edge N appears on output_data with valid_output=1 after edge N when the buffer was empty. Minimum latency is 1 cycle; there is no bypass.
- Throughput: with DEPTH>=2 and stop_output held 0, one push and one pop per cycle is sustained indefinitely.
- Full (cnt=DEPTH):
  - stop_input=1 for the whole cycle, even if a pop happens at the same edge.
  - A freed slot becomes visible one cycle later; no push can be lost because of this.
- Empty (cnt=0):
  - valid_output=0.
  - A simultaneous push is accepted. Pop cannot occur.
- Stalled output (valid_output=1 and stop_output=1):
  - output_data and valid_output hold stable until the pop edge.
  - rp does not move.
- Ordering: strict FIFO; no drop, duplication or reorder.
- Reset:
  - While reset_n=0, cnt, wp and rp are 0. So valid_output=0, stop_input=0 and occupancy=0.
  - mem contents are not reset.
  - Reset asserted mid-operation discards all stored entries immediately (asynchronous). Any push or pop at an edge while reset_n=0 is ignored.
  - After reset release, the first push is accepted at the next rising edge.
- Assertions (simulation only):
  - cnt never exceeds DEPTH and never underflows.
  - Flag producer protocol violations: input_data or valid_input changed while valid_input=1 and stop_input=1.

Test Plan:
- Reset then idle: reset_n low for 3 cycles, then release with valid_input=0 -> valid_output=0, stop_input=0, occupancy=0 for 10 cycles.
- Single datum: push 0xDEADBEEF at edge 1 with stop_output=0 -> valid_output=1 and output_data=0xDEADBEEF during cycle 2; pop at edge 2; occupancy returns to 0 after edge 2.
- Fill and stall (DEPTH=2): stop_output=1, push 0x11, then 0x22, then offer 0x33 -> occupancy=2, stop_input=1, 0x33 held by producer. Release stop_output -> outputs appear in order 0x11, 0x22, 0x33 with no loss. stop_input drops one cycle after the first pop.
- Streaming: 100 consecutive pushes 0..99 with stop_output=0 -> 100 pops in order, one per cycle after 1-cycle latency; occupancy stays at 1.
- Random back-pressure: random valid_input and stop_output (50%) for 10k cycles with DEPTH=2 and DEPTH=3 -> scoreboard matches in order, occupancy never exceeds DEPTH, output_data stable during every stall.
- Mid-operation reset: with occupancy=2, assert reset_n low asynchronously between edges -> valid_output and occupancy drop to 0 immediately. After release, push 0x55 -> 0x55 is the next output, with no stale entry.
